// File: rtl/pe_noc_inject.sv
// PE-to-router injection stage: buffers {dest, payload} requests and emits one 38-bit flit per credit.
// Latency: accept at edge N -> flit out after edge N+1; backpressure: o_req_ready low when full, sends stall at zero credits.
module pe_noc_inject #(
    parameter int unsigned ADDRESS     = 0,
    parameter int unsigned NUM_PE      = 8,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned NUM_CREDITS = 4,
    parameter bit          STAMP_SRC   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    input  logic [2:0]  i_req_dest,
    input  logic [31:0] i_req_data,
    output logic        o_req_ready,
    output logic [37:0] o_flit,
    output logic        o_flit_valid,
    input  logic        i_credit,
    output logic [31:0] o_sent_count,
    output logic        o_credit_err,
    output logic        o_idle
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(NUM_CREDITS + 1);
    localparam logic [CW-1:0] CRED_MAX  = CW'(NUM_CREDITS);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(DEPTH);
    localparam logic [7:0]    SRC_ID    = 8'(ADDRESS);

    if (NUM_PE > 8 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || NUM_CREDITS < 1) begin : g_cfg_check
        $error("pe_noc_inject: unsupported parameterisation");
    end

    logic [37:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] credits;
    logic          push;
    logic          send;
    logic          empty;
    logic          full;
    logic [31:0]   payload;

    assign full        = (count == FIFO_FULL);
    assign empty       = (count == '0);
    assign o_req_ready = !full;
    assign push        = i_req_valid && o_req_ready;
    assign send        = !empty && (credits != '0);
    assign payload     = STAMP_SRC ? {SRC_ID, i_req_data[23:0]} : i_req_data;
    assign o_idle      = empty && (credits == CRED_MAX) && !o_flit_valid;

    // Flits are formatted on the way in so the send path is a plain register load.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {1'b1, 1'b1, i_req_dest, 1'b0, payload};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            credits      <= CRED_MAX;
            o_flit       <= '0;
            o_flit_valid <= 1'b0;
            o_sent_count <= '0;
            o_credit_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end

            case ({push, send})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase

            o_flit_valid <= send;
            if (send) begin
                o_flit       <= mem[rd_ptr];
                rd_ptr       <= rd_ptr + AW'(1);
                o_sent_count <= o_sent_count + 32'd1;
            end

            // A credit returned with nothing outstanding is dropped and flagged.
            case ({send, i_credit})
                2'b10: credits <= credits - CW'(1);
                2'b01: begin
                    if (credits == CRED_MAX) begin
                        o_credit_err <= 1'b1;
                    end else begin
                        credits <= credits + CW'(1);
                    end
                end
                default: credits <= credits;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_noc_inject.sv
// Directed bench for pe_noc_inject (ADDRESS=5, DEPTH=4, NUM_CREDITS=2) with a flit scoreboard.
module tb_pe_noc_inject;

    localparam int DEPTH       = 4;
    localparam int NUM_CREDITS = 2;

    logic        clk;
    logic        rst;
    logic        i_req_valid;
    logic [2:0]  i_req_dest;
    logic [31:0] i_req_data;
    logic        o_req_ready;
    logic [37:0] o_flit;
    logic        o_flit_valid;
    logic        i_credit;
    logic [31:0] o_sent_count;
    logic        o_credit_err;
    logic        o_idle;

    pe_noc_inject #(
        .ADDRESS    (5),
        .NUM_PE     (8),
        .DEPTH      (DEPTH),
        .NUM_CREDITS(NUM_CREDITS),
        .STAMP_SRC  (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (i_req_valid),
        .i_req_dest  (i_req_dest),
        .i_req_data  (i_req_data),
        .o_req_ready (o_req_ready),
        .o_flit      (o_flit),
        .o_flit_valid(o_flit_valid),
        .i_credit    (i_credit),
        .o_sent_count(o_sent_count),
        .o_credit_err(o_credit_err),
        .o_idle      (o_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          nchk;
    int          nfail;
    int          npulse;
    logic [37:0] mfifo[$];
    int          mcred;
    logic [31:0] msent;
    logic        merr;
    logic [37:0] mflit;
    bit          last_acc;

    function automatic logic [37:0] fmt(input logic [2:0] d, input logic [31:0] x);
        return {1'b1, 1'b1, d, 1'b0, 8'd5, x[23:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check ready before the edge, update the model at the edge, check outputs after it.
    task automatic tick();
        bit          send_exp;
        bit          push;
        bit          ready_exp;
        logic [37:0] f_in;
        ready_exp = (mfifo.size() < DEPTH);
        if (!rst) chk("req_ready", o_req_ready, ready_exp);
        send_exp = (mfifo.size() != 0) && (mcred != 0);
        push     = i_req_valid && ready_exp;
        f_in     = fmt(i_req_dest, i_req_data);
        @(posedge clk);
        #1;
        if (rst) begin
            mfifo.delete();
            mcred    = NUM_CREDITS;
            msent    = '0;
            merr     = 1'b0;
            mflit    = '0;
            send_exp = 1'b0;
            push     = 1'b0;
        end else begin
            if (send_exp) begin
                mflit = mfifo.pop_front();
                msent = msent + 32'd1;
                if (!i_credit) mcred--;
            end
            if (push) mfifo.push_back(f_in);
            if (i_credit && !send_exp) begin
                if (mcred == NUM_CREDITS) merr = 1'b1;
                else mcred++;
            end
        end
        last_acc = push;
        if (o_flit_valid === 1'b1) npulse++;
        chk("flit_valid", o_flit_valid, send_exp);
        chk("flit", o_flit, mflit);
        chk("sent_count", o_sent_count, msent);
        chk("credit_err", o_credit_err, merr);
        chk("idle", o_idle, (mfifo.size() == 0) && (mcred == NUM_CREDITS) && !send_exp);
    endtask

    task automatic step(input bit v, input logic [2:0] d, input logic [31:0] x, input bit c);
        i_req_valid = v;
        i_req_dest  = d;
        i_req_data  = x;
        i_credit    = c;
        tick();
    endtask

    // Reset while a request is being offered, then one clean cycle.
    task automatic pulse_reset();
        rst         = 1'b1;
        i_req_valid = 1'b1;
        i_credit    = 1'b0;
        repeat (3) tick();
        rst         = 1'b0;
        i_req_valid = 1'b0;
        tick();
    endtask

    initial begin
        int idx;
        int acc5_cyc;
        nchk = 0; nfail = 0; npulse = 0;
        mcred = NUM_CREDITS; msent = '0; merr = 1'b0; mflit = '0;
        rst = 1'b1; i_req_valid = 1'b0; i_req_dest = '0; i_req_data = '0; i_credit = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_ready", o_req_ready, 1);
        chk("rst_idle", o_idle, 1);
        chk("rst_flit", o_flit, 0);

        // Latency and source stamping
        step(1'b1, 3'd3, 32'h0000_0064, 1'b0);
        chk("t2_not_yet", o_flit_valid, 0);
        step(1'b0, 3'd0, 32'h0, 1'b0);
        chk("t2_valid", o_flit_valid, 1);
        chk("t2_flit", o_flit, 38'h36_0500_0064);
        step(1'b0, 3'd0, 32'h0, 1'b1);

        // Credit stall
        pulse_reset();
        npulse = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 3'(i), 32'hA000_0000 + i, 1'b0);
        repeat (4) step(1'b0, 3'd0, 32'h0, 1'b0);
        chk("t3_stall_pulses", npulse, 2);
        step(1'b0, 3'd0, 32'h0, 1'b1);
        repeat (3) step(1'b0, 3'd0, 32'h0, 1'b0);
        chk("t3_pulses", npulse, 3);
        chk("t3_sent", o_sent_count, 3);

        // Full FIFO with credits exhausted
        pulse_reset();
        step(1'b1, 3'd1, 32'h1111_1111, 1'b0);
        step(1'b1, 3'd2, 32'h2222_2222, 1'b0);
        repeat (2) step(1'b0, 3'd0, 32'h0, 1'b0);
        idx = 0;
        acc5_cyc = -1;
        for (int cyc = 0; cyc < 40 && idx < 5; cyc++) begin
            if (cyc == 5) chk("t4_full_ready", o_req_ready, 0);
            step(1'b1, 3'(idx), 32'hB000_0000 + idx, cyc == 8);
            if (last_acc) begin
                idx++;
                if (idx == 5) acc5_cyc = cyc;
            end
        end
        chk("t4_all_accepted", idx, 5);
        chk("t4_accept_cycle", acc5_cyc, 10);
        i_req_valid = 1'b0;
        for (int k = 0; k < 20 && !(mfifo.size() == 0 && mcred == NUM_CREDITS); k++)
            step(1'b0, 3'd0, 32'h0, mcred < NUM_CREDITS);
        chk("t4_drained_idle", o_idle, 1);

        // Send coinciding with credit return
        step(1'b1, 3'd6, 32'hC000_0000, 1'b0);
        step(1'b0, 3'd0, 32'h0, 1'b0);
        npulse = 0;
        for (int k = 0; k < 7; k++) step(k < 6, 3'(k), 32'hD000_0000 + k, k >= 1);
        chk("t5_stream_pulses", npulse, 6);
        chk("t5_one_credit_out", o_idle, 0);
        step(1'b0, 3'd0, 32'h0, 1'b1);
        chk("t5_credit_restored", o_idle, 1);
        chk("t5_no_err", o_credit_err, 0);

        // Credit overflow is sticky
        step(1'b0, 3'd0, 32'h0, 1'b1);
        chk("t6_err_set", o_credit_err, 1);
        chk("t6_idle", o_idle, 1);
        npulse = 0;
        for (int k = 0; k < 3; k++) step(1'b1, 3'(k), 32'hE000_0000 + k, 1'b0);
        repeat (3) step(1'b0, 3'd0, 32'h0, 1'b0);
        chk("t6_credits_kept", npulse, 2);
        chk("t6_err_sticky", o_credit_err, 1);

        // Mid-traffic reset with one flit buffered and no credits
        pulse_reset();
        chk("t1_valid", o_flit_valid, 0);
        chk("t1_sent", o_sent_count, 0);
        chk("t1_ready", o_req_ready, 1);
        chk("t1_idle", o_idle, 1);
        chk("t1_err_clear", o_credit_err, 0);
        npulse = 0;
        repeat (3) step(1'b0, 3'd0, 32'h0, 1'b0);
        chk("t1_no_stale_flit", npulse, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
